// File: rtl/rv32e_mem_arbiter.sv
// rv32e_mem_arbiter
// Shares one memory port between the RV32E instruction-fetch path (I) and
// the load/store data path (D). One transaction is in flight at a time. The
// winner's fields are registered onto the memory port and held until m_ack.
// A watchdog aborts a transaction that never gets acknowledged.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate the grant between I
// and D when both request in the same cycle. When it is not defined, D wins
// every tie.
//
// Handshake summary (all outputs registered):
//   - i_req/d_req are sampled only while idle. A requester holds req until
//     it sees its 1-cycle gnt pulse. A request dropped before gnt is ignored.
//   - m_req rises together with the gnt pulse and stays high, with
//     m_we/m_addr/m_wdata/m_be stable, until the edge where m_ack is sampled
//     or the watchdog fires.
//   - Completion gives a 1-cycle rvalid pulse to the owner, with rdata valid
//     in that cycle. On a watchdog abort, err pulses in the same cycle and
//     rdata is 0.
//   - The cycle in which rvalid is high is idle, so a waiting request is
//     granted on the very next edge.
//   - m_ack is ignored outside a busy cycle.
module rv32e_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  // fetch path
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  // load/store path
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory port
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  // watchdog abort pulse
  output logic                err,
  // FSM state for checkers: 0 = IDLE, 1 = BUSY_I, 2 = BUSY_D
  output logic [1:0]          state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // The watchdog holds the number of busy cycles already spent without an
  // ack. The busy cycle in which it reads TIMEOUT-1 is the last one allowed.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wdog;
  logic             any_req;
  logic             grant_d;

  assign any_req   = i_req | d_req;
  assign state_dbg = state;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the most recent grant went to D. Reset to D, so the first tie
  // goes to I.
  logic last_d;

  // Alternate on a tie; a lone requester always wins.
  always_comb begin
    grant_d = d_req;
    if (i_req && d_req) begin
      grant_d = ~last_d;
    end
  end

  // Remember the owner of every grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_d <= grant_d;
    end
  end
`else
  // Fixed priority: D wins whenever it is requesting.
  always_comb begin
    grant_d = d_req;
  end
`endif

  // Main FSM: grant in IDLE, hold the memory port while BUSY, and complete
  // on ack or on watchdog expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wdog     <= '0;
      i_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_gnt    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      err      <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless they are set again below.
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (any_req) begin
            m_req <= 1'b1;
            if (grant_d) begin
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_be    <= d_be;
              d_gnt   <= 1'b1;
              state   <= BUSY_D;
            end else begin
              // A fetch is always a full-word read.
              m_we    <= 1'b0;
              m_addr  <= i_addr;
              m_wdata <= '0;
              m_be    <= '1;
              i_gnt   <= 1'b1;
              state   <= BUSY_I;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (m_ack) begin
            // An ack in the watchdog's last cycle still completes normally.
            m_req <= 1'b0;
            wdog  <= '0;
            state <= IDLE;
            if (state == BUSY_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= m_we ? '0 : m_rdata;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= m_we ? '0 : m_rdata;
            end
          end else if (wdog == WDOG_LAST) begin
            // Give the owner a zero response and flag the abort.
            m_req <= 1'b0;
            wdog  <= '0;
            err   <= 1'b1;
            state <= IDLE;
            if (state == BUSY_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= '0;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= '0;
            end
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Structural invariants of the two-path handshake.
  a_one_gnt : assert property (@(posedge clk) disable iff (reset) !(i_gnt && d_gnt));
  a_one_rvalid : assert property (@(posedge clk) disable iff (reset) !(i_rvalid && d_rvalid));
  a_err_has_rvalid : assert property (@(posedge clk) disable iff (reset) err |-> (i_rvalid || d_rvalid));

endmodule
